// File: rtl/comparador_8_bits.sv
// Registered 8-bit unsigned magnitude comparator built from two 4-bit slices.
// The high nibble decides unless it ties, in which case the low nibble resolves.
module comparador_8_bits (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       G,
    output logic       L,
    output logic       E
);

    // MSB-first cascade: the first differing bit fixes the result, so
    // lower bits only matter while every bit above them has tied.
    function automatic logic [2:0] cmp4(input logic [3:0] a, input logic [3:0] b);
        logic g;
        logic l;
        logic e;
        g = 1'b0;
        l = 1'b0;
        e = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (e) begin
                if (a[i] & ~b[i]) begin
                    g = 1'b1;
                    e = 1'b0;
                end else if (~a[i] & b[i]) begin
                    l = 1'b1;
                    e = 1'b0;
                end
            end
        end
        return {g, l, e};
    endfunction

    logic gh, lh, eh;
    logic gl, ll, el;
    logic g_d, l_d, e_d;
    logic g_q, l_q, e_q;

    always_comb begin
        {gh, lh, eh} = cmp4(A[7:4], B[7:4]);
        {gl, ll, el} = cmp4(A[3:0], B[3:0]);
        g_d = gh | (eh & gl);
        l_d = lh | (eh & ll);
        e_d = eh & el;
    end

    // Reset state matches the comparison of two zero operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q <= 1'b0;
            l_q <= 1'b0;
            e_q <= 1'b1;
        end else begin
            g_q <= g_d;
            l_q <= l_d;
            e_q <= e_d;
        end
    end

    assign G = g_q;
    assign L = l_q;
    assign E = e_q;

endmodule

// File: tb/tb_comparador_8_bits.sv
// Directed and exhaustive checks of the registered 8-bit comparator.
// Flags are compared as the 3-bit vector {G,L,E}.
module tb_comparador_8_bits;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       G;
    logic       L;
    logic       E;

    int vec_cnt  = 0;
    int fail_cnt = 0;

    localparam logic [2:0] FLAG_G = 3'b100;
    localparam logic [2:0] FLAG_L = 3'b010;
    localparam logic [2:0] FLAG_E = 3'b001;

    comparador_8_bits dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .G   (G),
        .L   (L),
        .E   (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst = 1'b1;
        A   = 8'h55;
        B   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {G, L, E};
            vec_cnt++;
            if (got !== FLAG_E) begin
                fail_cnt++;
                $display("FAIL reset_hold[%0d]: got GLE=%b expected %b", i, got, FLAG_E);
            end
        end
        rst = 1'b0;
        tick();
        got = {G, L, E};
        vec_cnt++;
        if (got !== FLAG_G) begin
            fail_cnt++;
            $display("FAIL reset_release: got GLE=%b expected %b", got, FLAG_G);
        end
    endtask

    task automatic test_equal_lsb();
        logic [7:0] av [3] = '{8'h40, 8'h41, 8'h40};
        logic [7:0] bv [3] = '{8'h40, 8'h40, 8'h41};
        logic [2:0] ev [3] = '{FLAG_E, FLAG_G, FLAG_L};
        logic [2:0] got;
        for (int i = 0; i < 3; i++) begin
            A = av[i];
            B = bv[i];
            tick();
            got = {G, L, E};
            vec_cnt++;
            if (got !== ev[i]) begin
                fail_cnt++;
                $display("FAIL equal_lsb A=%h B=%h: got GLE=%b expected %b", av[i], bv[i], got, ev[i]);
            end
        end
    endtask

    task automatic test_high_priority();
        logic [7:0] av [2] = '{8'h80, 8'h1F};
        logic [7:0] bv [2] = '{8'h7F, 8'h20};
        logic [2:0] ev [2] = '{FLAG_G, FLAG_L};
        logic [2:0] got;
        for (int i = 0; i < 2; i++) begin
            A = av[i];
            B = bv[i];
            tick();
            got = {G, L, E};
            vec_cnt++;
            if (got !== ev[i]) begin
                fail_cnt++;
                $display("FAIL high_priority A=%h B=%h: got GLE=%b expected %b", av[i], bv[i], got, ev[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [7:0] av [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        logic [7:0] bv [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        logic [2:0] ev [4] = '{FLAG_G, FLAG_L, FLAG_E, FLAG_E};
        logic [2:0] got;
        for (int i = 0; i < 4; i++) begin
            A = av[i];
            B = bv[i];
            tick();
            got = {G, L, E};
            vec_cnt++;
            if (got !== ev[i]) begin
                fail_cnt++;
                $display("FAIL extremes A=%h B=%h: got GLE=%b expected %b", av[i], bv[i], got, ev[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [2:0] got;
        A = 8'h10;
        B = 8'h20;
        tick();
        got = {G, L, E};
        vec_cnt++;
        if (got !== FLAG_L) begin
            fail_cnt++;
            $display("FAIL midstream_pre: got GLE=%b expected %b", got, FLAG_L);
        end
        rst = 1'b1;
        tick();
        got = {G, L, E};
        vec_cnt++;
        if (got !== FLAG_E) begin
            fail_cnt++;
            $display("FAIL midstream_rst: got GLE=%b expected %b", got, FLAG_E);
        end
        rst = 1'b0;
        tick();
        got = {G, L, E};
        vec_cnt++;
        if (got !== FLAG_L) begin
            fail_cnt++;
            $display("FAIL midstream_post: got GLE=%b expected %b", got, FLAG_L);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] got;
        logic [2:0] exp;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                A = a[7:0];
                B = b[7:0];
                tick();
                got = {G, L, E};
                exp = {(a > b), (a < b), (a == b)};
                vec_cnt++;
                if (got !== exp || $countones(got) != 1) begin
                    fail_cnt++;
                    $display("FAIL exhaustive A=%h B=%h: got GLE=%b expected %b", a[7:0], b[7:0], got, exp);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        A   = 8'h00;
        B   = 8'h00;
        test_reset();
        test_equal_lsb();
        test_high_priority();
        test_extremes();
        test_midstream_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/comparador_8_bits.md
Name: comparador_8_bits

Overview:
- Registered 8-bit unsigned magnitude comparator with three mutually exclusive flags: greater (G), less (L) and equal (E).
- Sits as a leaf datapath block.
- Internally built as a cascade of two 4-bit comparator slices. The high nibble has priority and the low nibble resolves ties.
- Flags are registered on the single clock and have a synchronous active-high reset.

Parameters:
- None. Width is fixed at 8 bits, split into two 4-bit slices.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous active-high reset
- A    input  8  operand A, unsigned, bit 7 = MSB
- B    input  8  operand B, unsigned, bit 7 = MSB
- G    output 1  registered flag, 1 when A > B
- L    output 1  registered flag, 1 when A < B
- E    output 1  registered flag, 1 when A == B

Interface:
- One clock; reset is synchronous and active-high.

Behaviour:
- Comparison is unsigned magnitude over all 8 bits. No signed mode.
- Slice structure:
  - High slice compares A[7:4] vs B[7:4], producing gh, lh, eh.
  - Low slice compares A[3:0] vs B[3:0], producing gl, ll, el.
  - Each slice is itself a bitwise MSB-first cascade.
- Combine rule:
  - G_next = gh | (eh & gl)
  - L_next = lh | (eh & ll)
  - E_next = eh & el
- Invariant: exactly one of G_next, L_next, E_next is 1 for every input pair.
- Registering: on each rising clk edge with rst=0, {G,L,E} <= {G_next,L_next,E_next}.
- Latency: 1 cycle. Outputs reflect the A/B values sampled at the previous rising edge.
- Throughput: one comparison per cycle. No handshake; inputs are sampled every cycle.
- Reset:
  - On a rising edge with rst=1: G=0, L=0, E=1, matching the comparison of two zero operands. Operands are ignored on that edge.
  - Reset has priority over a simultaneous operand change.
  - Asserted mid-stream, reset discards the pending result. The first valid result appears one edge after rst deasserts.
- Outputs remain stable between edges. Input glitches between edges must not reach G, L or E.
- Boundaries:
  - A=B=0x00 -> E.
  - A=B=0xFF -> E.
  - A=0xFF, B=0x00 -> G.
  - A=0x00, B=0xFF -> L.
  - A single-bit difference in bit 0 alone must resolve correctly, which exercises the full cascade.
- No X or Z may propagate from reset onward when the inputs are known.

Test Plan:
- Reset: hold rst=1 for 2 edges with A=0x55, B=0x00 -> G=0, L=0, E=1. Release and keep A=0x55, B=0x00 -> G=1 one edge later.
- Equal then LSB difference:
  - A=0x40, B=0x40 -> E=1.
  - Next cycle A=0x41, B=0x40 -> G=1.
  - Next cycle A=0x40, B=0x41 -> L=1.
  - Each result appears one edge after the inputs are applied.
- High-nibble priority:
  - A=0x80, B=0x7F -> G=1.
  - A=0x1F, B=0x20 -> L=1.
  - Confirms the low nibble is ignored when the high nibbles differ.
- Extremes:
  - A=0xFF, B=0x00 -> G.
  - A=0x00, B=0xFF -> L.
  - A=0xFF, B=0xFF -> E.
  - A=0x00, B=0x00 -> E.
- Mid-stream reset: stream A=0x10, B=0x20. Assert rst for one edge -> E=1, G=0, L=0 on that edge. The following edge gives L=1.
- Exhaustive check against a reference model:
  - Drive all 65536 A/B pairs on back-to-back cycles.
  - Every cycle, exactly one flag is set and it matches the inputs from the previous edge.
